// File: rtl/reorder_pkg.sv
// Shared tag arithmetic for the order-tag issuer and the reordering FIFO it feeds.
// Tags count modulo 2*depth so the FIFO can tell full from empty with one extra bit.
package reorder_pkg;

    function automatic int tag_mod(input int depth);
        return 2 * depth;
    endfunction

    function automatic int tag_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/order_tag_issuer_if.sv
// Request-in / tagged-request-out handshake bundle; slave is the issuer, master the bench or pipeline.
// Both directions use valid/ready; a transfer happens when valid and ready are high at the same edge.
interface order_tag_issuer_if #(
    parameter int WID  = 32,
    parameter int AWID = 3
);
    logic            req_vld;
    logic [WID-1:0]  req_data;
    logic            req_rdy;
    logic            out_vld;
    logic [WID-1:0]  out_data;
    logic [AWID:0]   out_tag;
    logic            out_rdy;

    modport master (
        output req_vld, req_data, out_rdy,
        input  req_rdy, out_vld, out_data, out_tag
    );

    modport slave (
        input  req_vld, req_data, out_rdy,
        output req_rdy, out_vld, out_data, out_tag
    );
endinterface

// File: rtl/mod_counter.sv
// Modulo-MOD up-counter with synchronous clear; clear wins over increment.
// Single-cycle update, no backpressure: inc is honoured on every edge it is high.
module mod_counter #(
    parameter int MOD = 16,
    parameter int W   = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    localparam logic [W-1:0] LAST = W'(MOD - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/order_tag_issuer.sv
// Stamps in-order requests with a modulo-2*DEPTH tag into a one-entry output register (1-cycle latency).
// Stalls upstream when the slot is blocked, DEPTH tags are outstanding, or softreset is high.
module order_tag_issuer
    import reorder_pkg::*;
#(
    parameter int WID   = 32,
    parameter int DEPTH = 8,
    parameter int AWID  = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      softreset,
    input  logic                      retire,
    order_tag_issuer_if.slave         bus,
    output logic [AWID:0]             outstanding,
    output logic                      no_credit,
    output logic                      err_underflow
);
    localparam int            TAG_MOD = tag_mod(DEPTH);
    localparam int            TW      = tag_width(DEPTH);
    localparam logic [AWID:0] FULL    = (AWID + 1)'(DEPTH);

    logic [TW-1:0] tag_next;
    logic          slot_free;
    logic          accept;

    // Ready depends only on registered state, out_rdy and softreset; never on req_vld or retire.
    assign no_credit   = (outstanding == FULL);
    assign slot_free   = !bus.out_vld || bus.out_rdy;
    assign bus.req_rdy = slot_free && !no_credit && !softreset;
    assign accept      = bus.req_vld && bus.req_rdy;

    mod_counter #(
        .MOD (TAG_MOD),
        .W   (TW)
    ) u_tag_next (
        .clk (clk),
        .rst (rst),
        .clr (softreset),
        .inc (accept),
        .cnt (tag_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_vld   <= 1'b0;
            bus.out_data  <= '0;
            bus.out_tag   <= '0;
            outstanding   <= '0;
            err_underflow <= 1'b0;
        end else if (softreset) begin
            bus.out_vld   <= 1'b0;
            bus.out_data  <= '0;
            bus.out_tag   <= '0;
            outstanding   <= '0;
            err_underflow <= 1'b0;
        end else begin
            if (accept) begin
                bus.out_vld  <= 1'b1;
                bus.out_data <= bus.req_data;
                bus.out_tag  <= tag_next;
            end else if (bus.out_rdy) begin
                bus.out_vld  <= 1'b0;
            end

            // Credit is taken at issue, so a request parked in the slot already counts.
            if (retire && outstanding == '0) begin
                err_underflow <= 1'b1;
            end
            if (accept && !retire) begin
                outstanding <= outstanding + 1'b1;
            end else if (!accept && retire && outstanding != '0) begin
                outstanding <= outstanding - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_order_tag_issuer.sv
// Bench for order_tag_issuer: directed scenarios plus random traffic, checked by a scoreboard
// against a reference model of tag sequence and credit count.
module tb_order_tag_issuer;
    localparam int WID   = 32;
    localparam int DEPTH = 8;
    localparam int AWID  = $clog2(DEPTH);
    localparam int TMOD  = 2 * DEPTH;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            softreset = 1'b0;
    logic            retire = 1'b0;
    logic [AWID:0]   outstanding;
    logic            no_credit;
    logic            err_underflow;

    order_tag_issuer_if #(.WID(WID), .AWID(AWID)) bus ();

    order_tag_issuer #(.WID(WID), .DEPTH(DEPTH), .AWID(AWID)) dut (
        .clk           (clk),
        .rst           (rst),
        .softreset     (softreset),
        .retire        (retire),
        .bus           (bus.slave),
        .outstanding   (outstanding),
        .no_credit     (no_credit),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: next tag = issued count mod 2*DEPTH, credits = issued - retired.
    int  m_tag = 0;
    int  m_out = 0;
    bit  m_vld = 0;
    bit  m_err = 0;
    logic [WID+AWID:0] sbq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_rdy(input bit ordy, input bit sr);
        return (!m_vld || ordy) && (m_out != DEPTH) && !sr;
    endfunction

    // Called just after a rising edge; applies inputs for one cycle and advances the model.
    task automatic cycle(input bit vld, input logic [WID-1:0] d, input bit ordy,
                         input bit ret, input bit sr);
        bit acc;
        bus.req_vld  = vld;
        bus.req_data = d;
        bus.out_rdy  = ordy;
        retire       = ret;
        softreset    = sr;
        acc = vld && m_rdy(ordy, sr);
        if (acc) sbq.push_back({d, AWID'(0) + (AWID + 1)'(m_tag)});
        @(posedge clk);
        #1;
        if (sr) begin
            m_tag = 0; m_out = 0; m_vld = 0; m_err = 0;
            sbq.delete();
        end else begin
            if (ret && m_out == 0) m_err = 1;
            if (acc) begin
                m_tag = (m_tag + 1) % TMOD;
                m_vld = 1;
            end else if (ordy) begin
                m_vld = 0;
            end
            if (acc && !ret) m_out++;
            else if (!acc && ret && m_out > 0) m_out--;
        end
    endtask

    task automatic idle_sr();
        cycle(0, '0, 1, 0, 1);
    endtask

    // Monitor: mid-cycle comparison of status outputs and in-order scoreboard of transfers.
    always @(negedge clk) begin
        logic [WID+AWID:0] e;
        if (!rst) begin
            chk("out_vld", bus.out_vld, m_vld);
            chk("req_rdy", bus.req_rdy, m_rdy(bus.out_rdy, softreset));
            chk("outstanding", outstanding, m_out);
            chk("no_credit", no_credit, m_out == DEPTH);
            chk("err_underflow", err_underflow, m_err);
            if (bus.out_vld && bus.out_rdy && !softreset) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_transfer", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("out_data", bus.out_data, e[WID+AWID:AWID+1]);
                    chk("out_tag", bus.out_tag, e[AWID:0]);
                end
            end
        end
    end

    initial begin
        bus.req_vld  = 1'b0;
        bus.req_data = '0;
        bus.out_rdy  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_out_vld", bus.out_vld, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_tag", bus.out_tag, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_no_credit", no_credit, 0);
        chk("rst_err", err_underflow, 0);
        chk("rst_req_rdy", bus.req_rdy, 1);
        @(posedge clk);
        #1;

        // Credit limit: ten requests, eight issued, then one retire frees one credit.
        idle_sr();
        for (int i = 0; i < 10; i++) cycle(1, $urandom, 1, 0, 0);
        chk("credit_outstanding", outstanding, DEPTH);
        chk("credit_no_credit", no_credit, 1);
        chk("credit_req_rdy_low", bus.req_rdy, 0);
        cycle(1, $urandom, 1, 1, 0);
        chk("credit_req_rdy_back", bus.req_rdy, 1);
        cycle(1, 32'h0000_0808, 1, 0, 0);
        chk("credit_tag8", bus.out_tag, 8);

        // Wrap: retire every cycle after the first keeps one tag in flight across the wrap.
        idle_sr();
        cycle(1, $urandom, 1, 0, 0);
        for (int i = 1; i < 20; i++) begin
            cycle(1, $urandom, 1, 1, 0);
            chk("wrap_outstanding_le1", outstanding <= 1, 1);
        end
        chk("wrap_last_tag", bus.out_tag, 3);
        cycle(0, '0, 1, 1, 0);

        // Backpressure on tag 5, then simultaneous accept and retire at outstanding 5.
        idle_sr();
        for (int i = 0; i < 5; i++) cycle(1, $urandom, 1, 0, 0);
        cycle(1, 32'hA5A5_A5A5, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(1, $urandom, 0, 0, 0);
            chk("bp_tag", bus.out_tag, 5);
            chk("bp_data", bus.out_data, 32'hA5A5_A5A5);
            chk("bp_req_rdy", bus.req_rdy, 0);
            chk("bp_outstanding", outstanding, 6);
        end
        cycle(0, '0, 1, 1, 0);
        chk("sim_pre_outstanding", outstanding, 5);
        cycle(1, 32'h1234_5678, 1, 1, 0);
        chk("sim_outstanding", outstanding, 5);
        chk("sim_tag", bus.out_tag, 6);
        cycle(0, '0, 1, 0, 0);

        // Underflow is sticky until softreset; tags restart from zero afterwards.
        idle_sr();
        cycle(0, '0, 1, 1, 0);
        chk("uf_err_set", err_underflow, 1);
        chk("uf_outstanding", outstanding, 0);
        cycle(0, '0, 1, 0, 0);
        chk("uf_err_sticky", err_underflow, 1);
        idle_sr();
        chk("uf_err_cleared", err_underflow, 0);
        cycle(1, 32'hCAFE_0000, 1, 0, 0);
        chk("uf_tag_restart", bus.out_tag, 0);
        cycle(0, '0, 1, 0, 0);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            cycle($urandom_range(0, 99) < 70, $urandom, $urandom_range(0, 99) < 65,
                  $urandom_range(0, 99) < 35, $urandom_range(0, 99) < 2);
        end

        // Mid-stream asynchronous reset with a held output.
        cycle(1, 32'hDEAD_BEEF, 0, 0, 0);
        bus.req_vld = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_out_vld", bus.out_vld, 0);
        chk("arst_out_data", bus.out_data, 0);
        chk("arst_out_tag", bus.out_tag, 0);
        chk("arst_outstanding", outstanding, 0);
        chk("arst_no_credit", no_credit, 0);
        chk("arst_err", err_underflow, 0);
        m_tag = 0; m_out = 0; m_vld = 0; m_err = 0;
        sbq.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("arst_req_rdy", bus.req_rdy, 1);
        @(posedge clk);
        #1;
        cycle(1, 32'h0BAD_F00D, 1, 0, 0);
        chk("arst_first_tag", bus.out_tag, 0);

        for (int i = 0; i < 4; i++) cycle(0, '0, 1, 0, 0);
        chk("scoreboard_drained", sbq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/order_tag_issuer.md
# order_tag_issuer

Front-end stage for an out-of-order target. It accepts in-order requests, stamps each one with a modulo-2·DEPTH order tag, and forwards it to the target. It also tracks outstanding requests with credits, so the downstream reordering FIFO (depth DEPTH, tag width AWID+1) can never overflow. Retire pulses come back from the reordering FIFO's read side and return credits.

## Interface
- WID, 32, request payload width
- DEPTH, 8, capacity of the downstream reordering FIFO; power of two, ≥2
- AWID, $clog2(DEPTH), index width; tags and counts are AWID+1 bits
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous reset, active-high
- softreset  in  1  synchronous clear, active-high
- req_vld  in  1  upstream request valid
- req_data  in  WID  upstream request payload
- req_rdy  out  1  request accepted this cycle when req_vld && req_rdy
- out_vld  out  1  tagged request valid to target
- out_data  out  WID  registered payload
- out_tag  out  AWID+1  registered order tag
- out_rdy  in  1  target accepts when out_vld && out_rdy
- retire  in  1  one entry drained from the reordering FIFO (its readout && !empty)
- outstanding  out  AWID+1  tags issued and not yet retired
- no_credit  out  1  outstanding == DEPTH
- err_underflow  out  1  sticky; retire seen while outstanding == 0

## Operation
- Tag counter `tag_next`, range 0..2·DEPTH−1.
  - Accept assigns out_tag = tag_next.
  - tag_next then increments, wrapping 2·DEPTH−1 → 0.
  - This matches the reordering FIFO's read sequence.
- One-entry output register holds out_vld/out_data/out_tag.
- `slot_free = !out_vld || out_rdy`.
- `req_rdy = slot_free && !no_credit && !softreset`. It is combinational from registers, out_rdy and softreset only. There is no path from req_vld or retire.
- Accept (`req_vld && req_rdy`):
  - load req_data and tag_next into the output register;
  - set out_vld;
  - advance tag_next;
  - outstanding +1.
- Slot drains (out_vld && out_rdy) with no accept: clear out_vld.
- outstanding update:
  - accept && retire → unchanged;
  - accept only → +1;
  - retire only, with outstanding > 0 → −1;
  - retire with outstanding == 0 → unchanged, and set err_underflow.
- Credit is consumed at issue, not at target acceptance. A request held in the output register counts as outstanding.
- While out_vld && !out_rdy: out_data and out_tag are held stable.
- softreset has priority over all other events:
  - clears tag_next, outstanding, out_vld and err_underflow;
  - drops any in-flight output;
  - req_rdy is 0 in that cycle.
- err_underflow clears only on rst or softreset.

## Timing
- Reset values: out_vld=0, out_data=0, out_tag=0, outstanding=0, no_credit=0, err_underflow=0, tag_next=0. req_rdy is therefore 1 after reset when softreset=0.
- Latency: request accepted at edge N appears on out_vld in the cycle after edge N (1 cycle).
- Throughput: one request per cycle while out_rdy=1 and credit is available.
- At outstanding == DEPTH: req_rdy=0 the same cycle. A retire at edge N makes req_rdy=1 in the cycle after edge N. There is no same-cycle credit bypass.
- Wrap: after tag 2·DEPTH−1 the next issued tag is 0, with no bubble.
- Mid-operation rst: all state clears immediately, asynchronously.

## Structure
- Shared package `reorder_pkg`:
  - `tag_mod(depth)` = 2·depth;
  - tag/count width helper (`$clog2(depth)+1`).
  - The reordering FIFO and this block both use it.
- Sub-module `mod_counter #(MOD, W)` with inc/clr. It implements tag_next.
- Outstanding counter and output register are inline.
- Target size: ~150–200 lines.

## Test plan
- Reset: assert rst mid-stream with out_vld=1 → all outputs 0 at once; req_rdy=1 after release.
- Credit limit: DEPTH=8, out_rdy=1, req_vld=1 for 10 cycles, no retire → tags 0..7 issued; req_rdy=0 from the cycle outstanding=8; no_credit=1. One retire → req_rdy=1 next cycle; tag 8 issued.
- Wrap: stream 20 requests with retire pulsed every cycle after the first → tags 0..15, 0..3; outstanding never exceeds 1.
- Backpressure: hold out_rdy=0 with out_vld=1 (tag 5, data 0xA5A5A5A5) for 4 cycles → out_tag/out_data stable; req_rdy=0; outstanding unchanged.
- Simultaneous: outstanding=5, accept and retire in the same cycle → outstanding stays 5; tag advances by 1.
- Underflow/softreset: retire at outstanding=0 → err_underflow=1 (sticky), outstanding stays 0. Then softreset for 1 cycle → err_underflow=0, next issued tag 0.
